// File: rtl/match_turn_ctrl.sv
// Turn sequencer for the 8-square colour-matching game: two picks per turn, timed reveal,
// colour compare, matched/pairs/moves bookkeeping and the step_2 phase code for the cursor block.
module match_turn_ctrl #(
    parameter int SHOW_CYCLES = 25_000_000
) (
    input  logic        clk25MHz,
    input  logic        rst_n,
    input  logic        select,
    input  logic        restart,
    input  logic [2:0]  cursor,
    input  logic [23:0] card_colors,
    output logic [3:0]  step_2,
    output logic [2:0]  first_sel,
    output logic [2:0]  second_sel,
    output logic [7:0]  revealed,
    output logic [7:0]  matched,
    output logic [2:0]  pairs,
    output logic [7:0]  moves,
    output logic        game_done
);

    localparam int TW = $clog2(SHOW_CYCLES);

    localparam logic [2:0] S_PICK1 = 3'd0;
    localparam logic [2:0] S_PICK2 = 3'd1;
    localparam logic [2:0] S_SHOW  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [TW-1:0] TIMER_LOAD = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [TW-1:0] TIMER_ZERO = TW'(0);

    function automatic logic [2:0] colour_of(input logic [23:0] colours, input logic [2:0] idx);
        logic [23:0] shifted;
        shifted = colours >> ({2'b00, idx} * 5'd3);
        return shifted[2:0];
    endfunction

    function automatic logic [3:0] phase_code(input logic [2:0] st);
        logic [3:0] code;
        case (st)
            S_PICK1: code = 4'b0000;
            S_PICK2: code = 4'b0000;
            S_SHOW:  code = 4'b0010;
            S_CHECK: code = 4'b0011;
            S_DONE:  code = 4'b1111;
            default: code = 4'b0000;
        endcase
        return code;
    endfunction

    logic [2:0]    r_state;
    logic          r_sel_q;
    logic [TW-1:0] r_timer;

    logic          w_press;
    logic [2:0]    w_state;
    logic [TW-1:0] w_timer;
    logic [2:0]    w_first_sel;
    logic [2:0]    w_second_sel;
    logic [7:0]    w_revealed;
    logic [7:0]    w_matched;
    logic [2:0]    w_pairs;
    logic [7:0]    w_moves;

    assign w_press = select & ~r_sel_q;

    // Next-state and next-output computation for the turn sequence
    always_comb begin
        w_state      = r_state;
        w_timer      = r_timer;
        w_first_sel  = first_sel;
        w_second_sel = second_sel;
        w_revealed   = revealed;
        w_matched    = matched;
        w_pairs      = pairs;
        w_moves      = moves;
        case (r_state)
            S_PICK1: begin
                if (w_press && !matched[cursor]) begin
                    w_first_sel = cursor;
                    w_revealed  = 8'd1 << cursor;
                    w_state     = S_PICK2;
                end else begin
                    w_state = S_PICK1;
                end
            end
            S_PICK2: begin
                if (w_press && (cursor != first_sel) && !matched[cursor]) begin
                    w_second_sel = cursor;
                    w_revealed   = revealed | (8'd1 << cursor);
                    w_timer      = TIMER_LOAD;
                    w_state      = S_SHOW;
                end else begin
                    w_state = S_PICK2;
                end
            end
            S_SHOW: begin
                if (r_timer == TIMER_ZERO) begin
                    w_state = S_CHECK;
                end else begin
                    w_timer = r_timer - TIMER_ONE;
                end
            end
            S_CHECK: begin
                if (colour_of(card_colors, first_sel) == colour_of(card_colors, second_sel)) begin
                    w_matched = matched | (8'd1 << first_sel) | (8'd1 << second_sel);
                    w_pairs   = pairs + 3'd1;
                end else begin
                    w_matched = matched;
                end
                w_revealed = 8'h00;
                if (moves != 8'hFF) begin
                    w_moves = moves + 8'd1;
                end else begin
                    w_moves = moves;
                end
                w_state = (w_matched == 8'hFF) ? S_DONE : S_PICK1;
            end
            S_DONE: begin
                if (restart) begin
                    w_matched    = 8'h00;
                    w_revealed   = 8'h00;
                    w_pairs      = 3'd0;
                    w_moves      = 8'd0;
                    w_first_sel  = 3'd0;
                    w_second_sel = 3'd0;
                    w_state      = S_PICK1;
                end else begin
                    w_state = S_DONE;
                end
            end
            default: begin
                w_state = S_PICK1;
            end
        endcase
    end

    // State and output registers; sel_q resets high so a press held through reset is ignored
    always_ff @(posedge clk25MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_PICK1;
            r_sel_q    <= 1'b1;
            r_timer    <= TIMER_ZERO;
            step_2     <= 4'b0000;
            first_sel  <= 3'd0;
            second_sel <= 3'd0;
            revealed   <= 8'h00;
            matched    <= 8'h00;
            pairs      <= 3'd0;
            moves      <= 8'd0;
            game_done  <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_sel_q    <= select;
            r_timer    <= w_timer;
            step_2     <= phase_code(w_state);
            first_sel  <= w_first_sel;
            second_sel <= w_second_sel;
            revealed   <= w_revealed;
            matched    <= w_matched;
            pairs      <= w_pairs;
            moves      <= w_moves;
            game_done  <= (w_state == S_DONE);
        end
    end

endmodule

// File: tb/tb_match_turn_ctrl.sv
// Bench for match_turn_ctrl: vector table, directed corner sequences and random play
// checked every cycle against a phase-level game model.
module tb_match_turn_ctrl;

    localparam int SHOW = 4;

    logic        clk25MHz = 1'b0;
    logic        rst_n    = 1'b0;
    logic        select   = 1'b1;
    logic        restart  = 1'b0;
    logic [2:0]  cursor   = 3'd0;
    logic [23:0] card_colors;
    logic [3:0]  step_2;
    logic [2:0]  first_sel, second_sel;
    logic [7:0]  revealed, matched;
    logic [2:0]  pairs;
    logic [7:0]  moves;
    logic        game_done;

    match_turn_ctrl #(.SHOW_CYCLES(SHOW)) dut (
        .clk25MHz(clk25MHz), .rst_n(rst_n), .select(select), .restart(restart),
        .cursor(cursor), .card_colors(card_colors), .step_2(step_2),
        .first_sel(first_sel), .second_sel(second_sel), .revealed(revealed),
        .matched(matched), .pairs(pairs), .moves(moves), .game_done(game_done)
    );

    always #5 clk25MHz = ~clk25MHz;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: phase 0 await first, 1 await second, 2 showing, 3 comparing, 4 game over
    int         m_phase;
    int         m_shown;
    bit         m_prev_sel;
    int         m_first, m_second, m_moves;
    bit [7:0]   m_rev, m_mat;
    int         colour [8];

    task automatic model_reset();
        m_phase = 0; m_shown = 0; m_prev_sel = 1'b1;
        m_first = 0; m_second = 0; m_moves = 0;
        m_rev = 8'h00; m_mat = 8'h00;
    endtask

    task automatic model_edge();
        bit pressed;
        int c;
        pressed = select && !m_prev_sel;
        m_prev_sel = select;
        c = int'(cursor);
        if (m_phase == 0) begin
            if (pressed && !m_mat[c]) begin m_first = c; m_rev = 8'h00; m_rev[c] = 1'b1; m_phase = 1; end
        end else if (m_phase == 1) begin
            if (pressed && c != m_first && !m_mat[c]) begin
                m_second = c; m_rev[c] = 1'b1; m_shown = 0; m_phase = 2;
            end
        end else if (m_phase == 2) begin
            m_shown++;
            if (m_shown == SHOW) m_phase = 3;
        end else if (m_phase == 3) begin
            if (colour[m_first] == colour[m_second]) begin m_mat[m_first] = 1'b1; m_mat[m_second] = 1'b1; end
            m_rev = 8'h00;
            m_moves = (m_moves + 1 > 255) ? 255 : m_moves + 1;
            m_phase = (m_mat == 8'hFF) ? 4 : 0;
        end else begin
            if (restart) begin
                m_mat = 8'h00; m_rev = 8'h00; m_moves = 0; m_first = 0; m_second = 0; m_phase = 0;
            end
        end
    endtask

    function automatic logic [37:0] model_vec();
        logic [3:0] st;
        st = (m_phase == 2) ? 4'h2 : (m_phase == 3) ? 4'h3 : (m_phase == 4) ? 4'hF : 4'h0;
        return {st, 3'(m_first), 3'(m_second), m_rev, m_mat, 3'($countones(m_mat) / 2),
                8'(m_moves), (m_phase == 4)};
    endfunction

    function automatic logic [37:0] dut_vec();
        return {step_2, first_sel, second_sel, revealed, matched, pairs, moves, game_done};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk25MHz);
        if (rst_n) model_edge();
        #1;
        chk("model", 64'(dut_vec()), 64'(model_vec()));
    endtask

    task automatic pick(input int c);
        select = 1'b0; step();
        cursor = 3'(c); select = 1'b1; step();
    endtask

    task automatic turn(input int a, input int b);
        pick(a); pick(b);
        select = 1'b0;
        for (int k = 0; k < SHOW + 1; k++) step();
    endtask

    typedef struct packed {
        logic       sel;
        logic [2:0] cur;
        logic [3:0] st;
        logic [7:0] rev;
        logic [7:0] mat;
        logic [2:0] pr;
        logic [7:0] mv;
    } vec_t;
    vec_t tbl [26];

    initial begin
        for (int i = 0; i < 8; i++) colour[i] = i % 4;
        for (int i = 0; i < 8; i++) card_colors[3*i +: 3] = 3'(i % 4);
        // sel, cur, step_2, revealed, matched, pairs, moves after the edge
        tbl[0]  = '{1'b1, 3'd0, 4'h0, 8'h00, 8'h00, 3'd0, 8'd0};
        tbl[1]  = '{1'b1, 3'd0, 4'h0, 8'h00, 8'h00, 3'd0, 8'd0};
        tbl[2]  = '{1'b0, 3'd0, 4'h0, 8'h00, 8'h00, 3'd0, 8'd0};
        tbl[3]  = '{1'b1, 3'd0, 4'h0, 8'h01, 8'h00, 3'd0, 8'd0};
        tbl[4]  = '{1'b1, 3'd4, 4'h0, 8'h01, 8'h00, 3'd0, 8'd0};
        tbl[5]  = '{1'b0, 3'd4, 4'h0, 8'h01, 8'h00, 3'd0, 8'd0};
        tbl[6]  = '{1'b1, 3'd4, 4'h2, 8'h11, 8'h00, 3'd0, 8'd0};
        tbl[7]  = '{1'b0, 3'd4, 4'h2, 8'h11, 8'h00, 3'd0, 8'd0};
        tbl[8]  = '{1'b0, 3'd4, 4'h2, 8'h11, 8'h00, 3'd0, 8'd0};
        tbl[9]  = '{1'b0, 3'd4, 4'h2, 8'h11, 8'h00, 3'd0, 8'd0};
        tbl[10] = '{1'b0, 3'd4, 4'h3, 8'h11, 8'h00, 3'd0, 8'd0};
        tbl[11] = '{1'b0, 3'd4, 4'h0, 8'h00, 8'h11, 3'd1, 8'd1};
        tbl[12] = '{1'b1, 3'd4, 4'h0, 8'h00, 8'h11, 3'd1, 8'd1};
        tbl[13] = '{1'b0, 3'd1, 4'h0, 8'h00, 8'h11, 3'd1, 8'd1};
        tbl[14] = '{1'b1, 3'd1, 4'h0, 8'h02, 8'h11, 3'd1, 8'd1};
        tbl[15] = '{1'b0, 3'd1, 4'h0, 8'h02, 8'h11, 3'd1, 8'd1};
        tbl[16] = '{1'b1, 3'd1, 4'h0, 8'h02, 8'h11, 3'd1, 8'd1};
        tbl[17] = '{1'b0, 3'd0, 4'h0, 8'h02, 8'h11, 3'd1, 8'd1};
        tbl[18] = '{1'b1, 3'd0, 4'h0, 8'h02, 8'h11, 3'd1, 8'd1};
        tbl[19] = '{1'b0, 3'd2, 4'h0, 8'h02, 8'h11, 3'd1, 8'd1};
        tbl[20] = '{1'b1, 3'd2, 4'h2, 8'h06, 8'h11, 3'd1, 8'd1};
        tbl[21] = '{1'b0, 3'd2, 4'h2, 8'h06, 8'h11, 3'd1, 8'd1};
        tbl[22] = '{1'b0, 3'd2, 4'h2, 8'h06, 8'h11, 3'd1, 8'd1};
        tbl[23] = '{1'b0, 3'd2, 4'h2, 8'h06, 8'h11, 3'd1, 8'd1};
        tbl[24] = '{1'b0, 3'd2, 4'h3, 8'h06, 8'h11, 3'd1, 8'd1};
        tbl[25] = '{1'b0, 3'd2, 4'h0, 8'h00, 8'h11, 3'd1, 8'd2};

        // reset held with select high, then released while select stays high
        model_reset();
        step(); step();
        chk("reset_vec", 64'(dut_vec()), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 26; i++) begin
            select = tbl[i].sel; cursor = tbl[i].cur;
            step();
            chk($sformatf("tbl%0d", i), 64'({step_2, revealed, matched, pairs, moves}),
                64'({tbl[i].st, tbl[i].rev, tbl[i].mat, tbl[i].pr, tbl[i].mv}));
        end

        // finish the game; select ignored in DONE; restart clears
        turn(1, 5); turn(2, 6); turn(3, 7);
        chk("done_state", 64'({step_2, matched, pairs, game_done}), 64'({4'hF, 8'hFF, 3'd4, 1'b1}));
        pick(0);
        chk("done_sel_ignored", 64'({step_2, revealed, game_done}), 64'({4'hF, 8'h00, 1'b1}));
        select = 1'b0; restart = 1'b1; step(); restart = 1'b0;
        chk("restart_clear", 64'(dut_vec()), 64'd0);

        // async reset mid-SHOW
        pick(1); pick(2); select = 1'b0; step(); step();
        chk("in_show", 64'(step_2), 64'h2);
        #3 rst_n = 1'b0; #1;
        chk("async_reset", 64'(dut_vec()), 64'd0);
        model_reset();
        #2 rst_n = 1'b1;

        // 260 mismatched turns: moves must saturate
        for (int t = 0; t < 260; t++) turn(1, 2);
        chk("moves_sat", 64'(moves), 64'd255);

        // random play against the model, restart allowed in any state
        for (int n = 0; n < 4000; n++) begin
            select  = ($urandom_range(0, 2) != 0);
            cursor  = 3'($urandom_range(0, 7));
            restart = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
